// File: rtl/mem_stage_if.sv
// mem_stage_if: request/response data-SRAM bus between the memory stage and the data SRAM.
interface mem_stage_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  modport master (output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
                  input  data_addr_ok, data_data_ok, data_rdata);
  modport slave  (input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
                  output data_addr_ok, data_data_ok, data_rdata);
endinterface

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage; issues SRAM accesses, aligns loads, builds store strobes, flags misalignment.
module mem_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic        in_mem_to_reg,
  input  logic        in_reg_write,
  input  logic [4:0]  in_write_reg,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  mem_stage_if.master dbus,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_reg,
  output logic        wb_we,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_inst,
  output logic        wb_exc_adel,
  output logic        wb_exc_ades,
  output logic [31:0] wb_badvaddr
);
  localparam logic [5:0] LB = 6'b100000, LH = 6'b100001, LBU = 6'b100100, LHU = 6'b100101;
  localparam logic [5:0] SB = 6'b101000, SH = 6'b101001;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, state_n;
  logic [31:0] a_q, d_q, inst_q, pc_q;
  logic [5:0]  op_q;
  logic [1:0]  sz_q;
  logic        wr_q, m2r_q, rw_q;
  logic [4:0]  rg_q;
  logic [5:0]  op;
  logic [1:0]  in_size;
  logic        in_mem, mis, accept;
  logic [31:0] sel, ld;
  assign op      = in_inst[31:26];
  // unknown opcodes with a memory control set fall through to word size
  assign in_size = (op == LB || op == LBU || op == SB) ? 2'd0 :
                   (op == LH || op == LHU || op == SH) ? 2'd1 : 2'd2;
  assign in_mem  = in_mem_read | in_mem_write;
  assign mis     = in_mem & (in_size == 2'd1 ? in_addr[0] : in_size == 2'd2 ? |in_addr[1:0] : 1'b0);
  assign accept  = in_valid & in_ready;
  assign sel     = dbus.data_rdata >> {a_q[1:0], 3'b000};
  assign ld      = op_q == LB  ? {{24{sel[7]}}, sel[7:0]} :
                   op_q == LBU ? {24'h0, sel[7:0]} :
                   op_q == LH  ? {{16{sel[15]}}, sel[15:0]} :
                   op_q == LHU ? {16'h0, sel[15:0]} : dbus.data_rdata;
  assign dbus.data_wr    = wr_q;
  assign dbus.data_size  = sz_q;
  assign dbus.data_addr  = a_q;
  assign dbus.data_wdata = sz_q == 2'd0 ? {4{d_q[7:0]}} : sz_q == 2'd1 ? {2{d_q[15:0]}} : d_q;
  assign dbus.data_wstrb = !wr_q ? 4'b0000 : sz_q == 2'd0 ? 4'b0001 << a_q[1:0] :
                           sz_q == 2'd1 ? 4'b0011 << a_q[1:0] : 4'b1111;
  always_comb begin
    in_ready      = state == IDLE;
    dbus.data_req = state == REQ;
    state_n       = state == IDLE ? (accept & in_mem & ~mis ? REQ : IDLE) :
                    state == REQ  ? (dbus.data_addr_ok ? WAIT : REQ) :
                    (dbus.data_data_ok ? IDLE : WAIT);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      {a_q, d_q, inst_q, pc_q, op_q, sz_q, wr_q, m2r_q, rw_q, rg_q} <= '0;
      wb_valid    <= 1'b0;
      wb_data     <= '0;
      wb_reg      <= '0;
      wb_we       <= 1'b0;
      wb_pc       <= RESET_PC;
      wb_inst     <= '0;
      wb_exc_adel <= 1'b0;
      wb_exc_ades <= 1'b0;
      wb_badvaddr <= '0;
    end else begin
      state    <= state_n;
      wb_valid <= 1'b0;
      if (accept && in_mem && !mis) begin
        {a_q, d_q, inst_q, pc_q} <= {in_addr, in_wdata, in_inst, in_pc};
        {op_q, sz_q, wr_q, m2r_q, rw_q, rg_q} <= {op, in_size, in_mem_write, in_mem_to_reg, in_reg_write, in_write_reg};
      end
      if (accept && (!in_mem || mis)) begin
        wb_valid    <= 1'b1;
        wb_data     <= in_addr;
        wb_reg      <= in_write_reg;
        wb_we       <= in_reg_write & ~mis;
        wb_pc       <= in_pc;
        wb_inst     <= in_inst;
        wb_exc_adel <= mis & in_mem_read;
        wb_exc_ades <= mis & in_mem_write;
        wb_badvaddr <= mis ? in_addr : 32'h0;
      end
      if (state == WAIT && dbus.data_data_ok) begin
        wb_valid    <= 1'b1;
        wb_data     <= m2r_q ? ld : a_q;
        wb_reg      <= rg_q;
        wb_we       <= rw_q;
        wb_pc       <= pc_q;
        wb_inst     <= inst_q;
        wb_exc_adel <= 1'b0;
        wb_exc_ades <= 1'b0;
        wb_badvaddr <= 32'h0;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of mem_stage covering ALU pass-through, loads, stores, misalignment and reset.
module tb_mem_stage;
  localparam logic [31:0] RPC = 32'hBFC0_0000;
  logic clk = 1'b0, rstn = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [31:0] in_addr = '0, in_wdata = '0, in_inst = '0, in_pc = '0;
  logic in_mem_read = 1'b0, in_mem_write = 1'b0, in_mem_to_reg = 1'b0, in_reg_write = 1'b0;
  logic [4:0] in_write_reg = '0;
  logic wb_valid, wb_we, wb_exc_adel, wb_exc_ades;
  logic [31:0] wb_data, wb_pc, wb_inst, wb_badvaddr;
  logic [4:0] wb_reg;
  int n_cmp = 0, n_bad = 0, req_cnt = 0;
  mem_stage_if dbus ();
  mem_stage #(.RESET_PC(RPC)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write), .in_write_reg(in_write_reg),
    .in_inst(in_inst), .in_pc(in_pc), .dbus(dbus),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_reg(wb_reg), .wb_we(wb_we), .wb_pc(wb_pc),
    .wb_inst(wb_inst), .wb_exc_adel(wb_exc_adel), .wb_exc_ades(wb_exc_ades), .wb_badvaddr(wb_badvaddr)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (dbus.data_req) req_cnt++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input logic rd, input logic wr, input logic m2r, input logic rw, input logic [4:0] rg);
    in_valid = 1'b1; in_inst = {op, 26'h0}; in_addr = a; in_wdata = wd; in_pc = a + 32'h10;
    in_mem_read = rd; in_mem_write = wr; in_mem_to_reg = m2r; in_reg_write = rw; in_write_reg = rg;
  endtask
  // accepts a memory op, plays the SRAM with the given delays, returns on the wb_valid cycle
  task automatic run_mem(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input logic rd, input logic wr, input logic m2r, input logic rw, input logic [4:0] rg,
                         input int ad, input int dd, input logic [31:0] rdat,
                         input logic [1:0] e_size, input logic [3:0] e_strb, input logic [31:0] e_wdata);
    drive(op, a, wd, rd, wr, m2r, rw, rg);
    @(negedge clk);
    in_valid = 1'b0;
    check("req_ready", in_ready, 0);
    check("req_size", dbus.data_size, e_size);
    check("req_wr", dbus.data_wr, wr);
    check("req_addr", dbus.data_addr, a);
    check("req_strb", dbus.data_wstrb, e_strb);
    check("req_wdata", dbus.data_wdata, e_wdata);
    for (int i = 0; i < ad; i++) begin
      check("req_hold", dbus.data_req, 1);
      @(negedge clk);
    end
    check("req_on", dbus.data_req, 1);
    dbus.data_addr_ok = 1'b1;
    @(negedge clk);
    dbus.data_addr_ok = 1'b0;
    check("wait_req", dbus.data_req, 0);
    for (int i = 0; i < dd; i++) begin
      check("wait_ready", in_ready, 0);
      @(negedge clk);
    end
    check("wait_ready", in_ready, 0);
    dbus.data_data_ok = 1'b1;
    dbus.data_rdata = rdat;
    @(negedge clk);
    dbus.data_data_ok = 1'b0;
    check("done_valid", wb_valid, 1);
  endtask
  initial begin
    dbus.data_addr_ok = 1'b0; dbus.data_data_ok = 1'b0; dbus.data_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", wb_valid, 0);
    check("rst_pc", wb_pc, RPC);
    check("rst_data", wb_data, 0);
    check("rst_req", dbus.data_req, 0);
    rstn = 1'b1;
    // 1: ALU op
    drive(6'b000000, 32'h1234, 32'h0, 0, 0, 0, 1, 5'd5);
    @(negedge clk);
    in_valid = 1'b0;
    check("alu_valid", wb_valid, 1);
    check("alu_data", wb_data, 32'h1234);
    check("alu_reg", wb_reg, 5);
    check("alu_we", wb_we, 1);
    check("alu_pc", wb_pc, 32'h1244);
    @(negedge clk);
    check("alu_pulse", wb_valid, 0);
    check("alu_noreq", req_cnt, 0);
    // 2: LB / LBU at offset 3
    run_mem(6'b100000, 32'h1003, 32'h0, 1, 0, 1, 1, 5'd8, 2, 1, 32'h80AA_BBCC, 2'd0, 4'b0000, 32'h0);
    check("lb_data", wb_data, 32'hFFFF_FF80);
    check("lb_reg", wb_reg, 8);
    check("lb_we", wb_we, 1);
    @(negedge clk);
    check("lb_pulse", wb_valid, 0);
    run_mem(6'b100100, 32'h1003, 32'h0, 1, 0, 1, 1, 5'd8, 2, 1, 32'h80AA_BBCC, 2'd0, 4'b0000, 32'h0);
    check("lbu_data", wb_data, 32'h0000_0080);
    @(negedge clk);
    // LH at offset 2
    run_mem(6'b100001, 32'h1002, 32'h0, 1, 0, 1, 1, 5'd9, 0, 0, 32'h80AA_BBCC, 2'd1, 4'b0000, 32'h0);
    check("lh_data", wb_data, 32'hFFFF_80AA);
    @(negedge clk);
    // 3: SH upper half
    run_mem(6'b101001, 32'h2002, 32'hDEAD_BEEF, 0, 1, 0, 0, 5'd0, 0, 0, 32'h0, 2'd1, 4'b1100, 32'hBEEF_BEEF);
    check("sh_we", wb_we, 0);
    check("sh_data", wb_data, 32'h2002);
    @(negedge clk);
    run_mem(6'b101000, 32'h2001, 32'h0000_0077, 0, 1, 0, 0, 5'd0, 0, 0, 32'h0, 2'd0, 4'b0010, 32'h7777_7777);
    @(negedge clk);
    // 4: misaligned load and store
    req_cnt = 0;
    drive(6'b100011, 32'h3002, 32'h0, 1, 0, 1, 1, 5'd3);
    @(negedge clk);
    drive(6'b101001, 32'h3001, 32'h0, 0, 1, 0, 0, 5'd0);
    check("adel_valid", wb_valid, 1);
    check("adel_flag", wb_exc_adel, 1);
    check("adel_other", wb_exc_ades, 0);
    check("adel_bva", wb_badvaddr, 32'h3002);
    check("adel_we", wb_we, 0);
    check("adel_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("ades_valid", wb_valid, 1);
    check("ades_flag", wb_exc_ades, 1);
    check("ades_other", wb_exc_adel, 0);
    check("ades_bva", wb_badvaddr, 32'h3001);
    @(negedge clk);
    check("mis_pulse", wb_valid, 0);
    check("mis_noreq", req_cnt, 0);
    // 5: LW then ALU back to back
    run_mem(6'b100011, 32'h4000, 32'h0, 1, 0, 1, 1, 5'd7, 1, 1, 32'h1122_3344, 2'd2, 4'b0000, 32'h0);
    check("lw_data", wb_data, 32'h1122_3344);
    check("lw_reg", wb_reg, 7);
    check("b2b_ready", in_ready, 1);
    drive(6'b000000, 32'h5555, 32'h0, 0, 0, 0, 1, 5'd9);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_valid", wb_valid, 1);
    check("b2b_data", wb_data, 32'h5555);
    check("b2b_reg", wb_reg, 9);
    @(negedge clk);
    check("b2b_pulse", wb_valid, 0);
    // 6: reset during WAIT, then stray data_ok
    drive(6'b100011, 32'h6000, 32'h0, 1, 0, 1, 1, 5'd4);
    @(negedge clk);
    in_valid = 1'b0;
    dbus.data_addr_ok = 1'b1;
    @(negedge clk);
    dbus.data_addr_ok = 1'b0;
    check("w_ready", in_ready, 0);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    dbus.data_data_ok = 1'b1;
    dbus.data_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    dbus.data_data_ok = 1'b0;
    check("stray_valid", wb_valid, 0);
    check("stray_req", dbus.data_req, 0);
    check("stray_ready", in_ready, 1);
    check("stray_data", wb_data, 0);
    @(negedge clk);
    check("stray_valid2", wb_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
